// File: rtl/card_shoe.sv
// card_shoe: finite multi-deck card source for the BlackJack datapath.
//
// A free-running rank counter (1..NUM_RANKS) picks the starting rank of
// each draw. Per-rank remaining counts model a shoe of DECKS decks.
// Depleted ranks are skipped by walking the pointer upward with wrap.
//
// Ports:
//   clock       system clock, rising edge
//   reset_n     asynchronous active-low reset
//   run         1 = rank counter advances every cycle
//   shuffle     synchronous reload of the full shoe; aborts a search
//   draw_req    request one card; sampled only while idle
//   card        last dealt card value, held until the next deal
//   card_valid  one-cycle pulse when card is updated
//   busy        high while searching for a non-depleted rank
//   empty       high when cards_left == 0
//   cards_left  total cards remaining in the shoe
//
// Build option: define CARD_SHOE_INFINITE_EN for an infinite shoe. Counts
// are never decremented, cards_left stays full and empty is tied low.

module card_shoe #(
  parameter int unsigned NUM_RANKS  = 10,
  parameter int unsigned DECKS      = 1,
  parameter int unsigned TEN_MULT   = 4,
  parameter int unsigned CARD_W     = 5,
  parameter int unsigned RANK_CNT_W = 8,
  parameter int unsigned LEFT_W     = 9
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              run,
  input  logic              shuffle,
  input  logic              draw_req,
  output logic [CARD_W-1:0] card,
  output logic              card_valid,
  output logic              busy,
  output logic              empty,
  output logic [LEFT_W-1:0] cards_left
);

  localparam int unsigned RANK_W = $clog2(NUM_RANKS + 1);
  localparam logic [RANK_CNT_W-1:0] RankFull = RANK_CNT_W'(4 * DECKS);
  localparam logic [RANK_CNT_W-1:0] TenFull  = RANK_CNT_W'(4 * DECKS * TEN_MULT);
  localparam logic [LEFT_W-1:0]     LeftFull =
      LEFT_W'(4 * DECKS * (NUM_RANKS - 1 + TEN_MULT));

  typedef enum logic [0:0] {StIdle, StSearch} state_e;

  state_e                state_q, state_d;
  logic [RANK_W-1:0]     rank_q;
  logic [RANK_W-1:0]     ptr_q, ptr_d;
  logic [RANK_W-1:0]     ptr_idx;
  logic [RANK_CNT_W-1:0] remaining_q [NUM_RANKS];
  logic [RANK_CNT_W-1:0] ptr_count;
  logic [LEFT_W-1:0]     cards_left_q;
  logic [CARD_W-1:0]     card_q;
  logic                  card_valid_q;
  logic                  shoe_empty;
  logic                  hit;
  logic                  deal;

  // Rank r is stored at array index r-1.
  assign ptr_idx   = ptr_q - RANK_W'(1);
  assign ptr_count = remaining_q[ptr_idx];
  assign hit       = (ptr_count != '0);
  assign deal      = !shuffle && (state_q == StSearch) && hit;

`ifdef CARD_SHOE_INFINITE_EN
  assign shoe_empty = 1'b0;
`else
  assign shoe_empty = (cards_left_q == '0);
`endif

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      ptr_q   <= RANK_W'(1);
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (shuffle) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (draw_req && !shoe_empty) begin
            state_d = StSearch;
            ptr_d   = rank_q;
          end
        end
        StSearch: begin
          if (hit) begin
            state_d = StIdle;
          end else begin
            ptr_d = (ptr_q == RANK_W'(NUM_RANKS)) ? RANK_W'(1) : ptr_q + RANK_W'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    busy = (state_q == StSearch);
  end

  // Datapath: rank counter, shoe counts, dealt card
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rank_q       <= RANK_W'(1);
      card_q       <= '0;
      card_valid_q <= 1'b0;
      cards_left_q <= LeftFull;
      for (int i = 0; i < int'(NUM_RANKS); i++) begin
        remaining_q[i] <= (i == int'(NUM_RANKS) - 1) ? TenFull : RankFull;
      end
    end else begin
      card_valid_q <= deal;
      if (run) begin
        rank_q <= (rank_q == RANK_W'(NUM_RANKS)) ? RANK_W'(1) : rank_q + RANK_W'(1);
      end
      if (deal) begin
        card_q <= CARD_W'(ptr_q);
      end
      if (shuffle) begin
        cards_left_q <= LeftFull;
        for (int i = 0; i < int'(NUM_RANKS); i++) begin
          remaining_q[i] <= (i == int'(NUM_RANKS) - 1) ? TenFull : RankFull;
        end
      end else if (deal) begin
`ifndef CARD_SHOE_INFINITE_EN
        remaining_q[ptr_idx] <= ptr_count - RANK_CNT_W'(1);
        cards_left_q         <= cards_left_q - LEFT_W'(1);
`endif
      end
    end
  end

  assign card       = card_q;
  assign card_valid = card_valid_q;
  assign empty      = shoe_empty;
  assign cards_left = cards_left_q;

endmodule

// File: tb/tb_card_shoe.sv
module tb_card_shoe;

  localparam int N = 10;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       run = 1'b0;
  logic       shuffle = 1'b0;
  logic       draw_req = 1'b0;
  logic [4:0] card;
  logic       card_valid;
  logic       busy;
  logic       empty;
  logic [8:0] cards_left;

  int tests = 0;
  int fails = 0;

  card_shoe dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .run        (run),
    .shuffle    (shuffle),
    .draw_req   (draw_req),
    .card       (card),
    .card_valid (card_valid),
    .busy       (busy),
    .empty      (empty),
    .cards_left (cards_left)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: a draw is resolved the moment it is accepted (first
  // non-empty rank from the counter, k skips), then delivered after k+1 edges.
  int m_rank, m_left, m_card, m_valid, m_timer, m_pend;
  int m_cnt [1:N];

  function automatic int full_of(input int r);
    return (r == N) ? 16 : 4;
  endfunction

  task automatic model_reload();
    for (int r = 1; r <= N; r++) m_cnt[r] = full_of(r);
    m_left = 52;
  endtask

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_rank = 1; m_card = 0; m_valid = 0; m_timer = 0; m_pend = 0;
      model_reload();
    end else begin
      int c;
      int k;
      m_valid = 0;
      if (shuffle) begin
        model_reload();
        m_timer = 0;
      end else if (m_timer > 0) begin
        m_timer--;
        if (m_timer == 0) begin
`ifndef CARD_SHOE_INFINITE_EN
          m_cnt[m_pend]--;
          m_left--;
`endif
          m_card  = m_pend;
          m_valid = 1;
        end
      end else if (draw_req && m_left > 0) begin
        c = m_rank;
        k = 0;
        while (m_cnt[c] == 0) begin
          c = (c == N) ? 1 : c + 1;
          k++;
        end
        m_pend  = c;
        m_timer = k + 1;
      end
      if (run) m_rank = (m_rank == N) ? 1 : m_rank + 1;
    end
  end

  // Per-cycle compare against the model
  always @(negedge clock) begin
    if (reset_n) begin
      chk("card", int'(card), m_card);
      chk("card_valid", int'(card_valid), m_valid);
      chk("busy", int'(busy), (m_timer > 0) ? 1 : 0);
      chk("empty", int'(empty), (m_left == 0) ? 1 : 0);
      chk("cards_left", int'(cards_left), m_left);
    end
  end

  // Called at a falling edge; lat counts falling edges until card_valid.
  task automatic do_draw(output int c, output int lat);
    draw_req = 1'b1;
    @(negedge clock);
    draw_req = 1'b0;
    lat = 1;
    while (!card_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    c = int'(card);
    if (!card_valid) lat = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int c, lat, drawn;
    int hist [1:N];

    repeat (3) @(negedge clock);
    #2 reset_n = 1'b1;
    @(negedge clock);
    chk("rst_card", int'(card), 0);
    chk("rst_valid", int'(card_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_empty", int'(empty), 0);
    chk("rst_left", int'(cards_left), 52);

`ifndef CARD_SHOE_INFINITE_EN
    for (int r = 1; r <= N; r++) hist[r] = 0;
    // First draw at run=0: busy one cycle, card 1 at latency 2
    draw_req = 1'b1;
    @(negedge clock);
    draw_req = 1'b0;
    chk("first_busy", int'(busy), 1);
    @(negedge clock);
    chk("first_valid", int'(card_valid), 1);
    chk("first_card", int'(card), 1);
    chk("first_left", int'(cards_left), 51);
    hist[1]++;
    drawn = 1;
    for (int i = 0; i < 3; i++) begin
      do_draw(c, lat);
      chk("ones_card", c, 1);
      chk("ones_lat", lat, 2);
      hist[c]++;
      drawn++;
    end
    do_draw(c, lat);
    chk("skip_card", c, 2);
    chk("skip_lat", lat, 3);
    chk("skip_left", int'(cards_left), 47);
    hist[c]++;
    drawn++;

    // Drain the shoe with the rank counter toggling
    for (int i = 0; i < 60 && !empty; i++) begin
      run = 1'($urandom);
      do_draw(c, lat);
      if (lat < 0) break;
      if (c >= 1 && c <= N) hist[c]++;
      drawn++;
    end
    run = 1'b0;
    chk("drained_count", drawn, 52);
    for (int r = 1; r <= N; r++) chk("hist", hist[r], (r == N) ? 16 : 4);
    do_draw(c, lat);
    chk("empty_draw_ignored", lat, -1);
    chk("empty_flag", int'(empty), 1);
    chk("empty_left", int'(cards_left), 0);

    // Refill, park counter at 10, deplete the ten rank
    shuffle = 1'b1;
    @(negedge clock);
    shuffle = 1'b0;
    chk("shuffle_left", int'(cards_left), 52);
    run = 1'b1;
    for (int i = 0; i < 20 && m_rank != N; i++) @(negedge clock);
    run = 1'b0;
    for (int i = 0; i < 16; i++) begin
      do_draw(c, lat);
      chk("tens_card", c, 10);
    end
    do_draw(c, lat);
    chk("wrap_card", c, 1);
    chk("wrap_lat", lat, 3);

    // Shuffle during a search aborts it
    draw_req = 1'b1;
    @(negedge clock);
    draw_req = 1'b0;
    chk("abort_busy_before", int'(busy), 1);
    shuffle = 1'b1;
    @(negedge clock);
    shuffle = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_valid", int'(card_valid), 0);
    chk("abort_left", int'(cards_left), 52);
    chk("abort_card_held", int'(card), 1);
    @(negedge clock);
    chk("abort_no_late_valid", int'(card_valid), 0);

    // Asynchronous reset mid-search
    do_draw(c, lat);
    draw_req = 1'b1;
    @(negedge clock);
    draw_req = 1'b0;
    chk("areset_busy_before", int'(busy), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("areset_card", int'(card), 0);
    chk("areset_busy", int'(busy), 0);
    chk("areset_valid", int'(card_valid), 0);
    chk("areset_left", int'(cards_left), 52);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Randomised traffic against the model
    for (int i = 0; i < 600; i++) begin
      @(negedge clock);
      run      = 1'($urandom);
      draw_req = ($urandom_range(0, 3) != 0);
      shuffle  = ($urandom_range(0, 79) == 0);
    end
    draw_req = 1'b0;
    shuffle  = 1'b0;
`else
    for (int i = 0; i < 60; i++) begin
      do_draw(c, lat);
      chk("inf_card", c, 1);
      chk("inf_lat", lat, 2);
      chk("inf_empty", int'(empty), 0);
    end
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      run      = 1'($urandom);
      draw_req = 1'($urandom);
      shuffle  = ($urandom_range(0, 49) == 0);
    end
    draw_req = 1'b0;
    shuffle  = 1'b0;
`endif
    repeat (3) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
